// File: rtl/cipu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cipu_pkg                                                  |
// | Desc   : Shared state encoding and framing characters for the      |
// |          CIPU output merger.                                       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package cipu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        THING = 3'd1,
        PASS  = 3'd2,
        TERM  = 3'd3,
        DONE  = 3'd4
    } cipu_state_e;

    localparam logic [7:0] SEP_CHAR  = 8'h3B;  // ';'
    localparam logic [7:0] TERM_CHAR = 8'h24;  // '$'

endpackage
`default_nettype wire

// File: rtl/cipu_char_q.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cipu_char_q                                               |
// | Desc   : Synchronous byte FIFO with same-cycle push/pop; pushes    |
// |          into a full queue are ignored (caller flags the drop).    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module cipu_char_q #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cipu_out_merger.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cipu_out_merger                                           |
// | Desc   : Buffers CIPU thing/passenger streams and serialises them  |
// |          as "things ; ... passengers $" on a valid/ready byte bus. |
// |          Define CIPU_MERGE_CNT_EN to add pass_cnt/thing_cnt.        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module cipu_out_merger
    import cipu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_fifo,
    input  logic [7:0]    people_thing_out,
    input  logic          done_fifo,
    input  logic          valid_lifo,
    input  logic [7:0]    thing_out,
    input  logic          done_thing,
    input  logic          done_lifo,
    output logic          ready_fifo,
    output logic          ready_lifo,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          overflow_err
`ifdef CIPU_MERGE_CNT_EN
    ,
    output logic [AW:0]   pass_cnt,
    output logic [AW:0]   thing_cnt
`endif
);

    localparam logic [AW:0] c_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_TQ_LIMIT  = (AW+1)'(DEPTH - 2);

    cipu_state_e r_state;
    cipu_state_e w_next_state;

    logic        r_done_p;
    logic        r_done_t;
    logic        r_sep_pending;
    logic        r_out_thing;

    logic        w_active;
    logic        w_in_thing;
    logic        w_load;
    logic        w_pq_push, w_pq_pop, w_pq_full, w_pq_empty;
    logic        w_tq_push, w_tq_pop, w_tq_full, w_tq_empty;
    logic [7:0]  w_pq_head, w_tq_head, w_tq_data;
    logic [AW:0] w_pq_count, w_tq_count;
    logic        w_sep_set;
    logic        w_tq_lost;
    logic        w_drop;

    assign w_active   = (r_state == THING) || (r_state == PASS) || (r_state == TERM);
    assign w_in_thing = (r_state == THING);
    assign w_load     = !out_valid || out_ready;

    assign w_pq_push  = w_active && valid_fifo;
    // While the deferred ';' is being written, the thing write port is busy.
    assign w_tq_push  = w_in_thing && (r_sep_pending || valid_lifo || done_thing);
    assign w_tq_data  = (r_sep_pending || !valid_lifo) ? SEP_CHAR : thing_out;
    assign w_sep_set  = w_in_thing && !r_sep_pending && valid_lifo && done_thing;
    assign w_tq_lost  = (valid_lifo || done_thing) &&
                        ((r_state == PASS) || (r_state == TERM) || (w_in_thing && r_sep_pending));
    assign w_drop     = (w_pq_push && w_pq_full) || (w_tq_push && w_tq_full) || w_tq_lost;

    assign w_pq_pop   = (r_state == PASS)  && w_load && !w_pq_empty;
    assign w_tq_pop   = (r_state == THING) && w_load && !w_tq_empty;

    assign ready_fifo = w_active && (w_pq_count < c_DEPTH);
    assign ready_lifo = w_active && (w_tq_count <= c_TQ_LIMIT) && !r_sep_pending;

    cipu_char_q #(.DEPTH(DEPTH), .AW(AW)) u_pq (
        .clk       (clk),
        .rst       (rst),
        .push      (w_pq_push),
        .push_data (people_thing_out),
        .pop       (w_pq_pop),
        .pop_data  (w_pq_head),
        .full      (w_pq_full),
        .empty     (w_pq_empty),
        .count     (w_pq_count)
    );

    cipu_char_q #(.DEPTH(DEPTH), .AW(AW)) u_tq (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tq_push),
        .push_data (w_tq_data),
        .pop       (w_tq_pop),
        .pop_data  (w_tq_head),
        .full      (w_tq_full),
        .empty     (w_tq_empty),
        .count     (w_tq_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = THING;
            // Leave only once no thing char can still be in flight into tq.
            THING: if (r_done_t && w_tq_empty && !r_sep_pending && !w_tq_push && w_load)
                       w_next_state = PASS;
            PASS:  if (r_done_p && w_pq_empty && !w_pq_push)
                       w_next_state = TERM;
            TERM:  if (w_load && out_valid && out_last)
                       w_next_state = DONE;
            DONE:  w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done_p      <= 1'b0;
            r_done_t      <= 1'b0;
            r_sep_pending <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            r_done_p      <= r_done_p || done_fifo;
            r_done_t      <= r_done_t || done_lifo;
            r_sep_pending <= w_sep_set;
            overflow_err  <= overflow_err || w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            out_last    <= 1'b0;
            r_out_thing <= 1'b0;
        end else if (w_load) begin
            case (r_state)
                THING: begin
                    out_valid   <= !w_tq_empty;
                    out_last    <= 1'b0;
                    r_out_thing <= 1'b1;
                    if (!w_tq_empty) out_data <= w_tq_head;
                end
                PASS: begin
                    out_valid   <= !w_pq_empty;
                    out_last    <= 1'b0;
                    r_out_thing <= 1'b0;
                    if (!w_pq_empty) out_data <= w_pq_head;
                end
                TERM: begin
                    // A '$' already in the register is being accepted now.
                    if (out_valid && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_data  <= TERM_CHAR;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CIPU_MERGE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_cnt  <= '0;
            thing_cnt <= '0;
        end else if (out_valid && out_ready && !out_last) begin
            if (r_out_thing) begin
                if (thing_cnt != '1) thing_cnt <= thing_cnt + 1'b1;
            end else begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/cipu_out_merger.md
Name: cipu_out_merger

Overview:
- Downstream stage of the CIPU passenger/baggage processor.
- Consumes CIPU's two output streams: passenger chars (people_thing_out / valid_fifo) and thing chars (thing_out / valid_lifo).
- Buffers both streams and serialises them onto one byte stream with valid/ready handshake: thing section (groups separated by ';'), then passenger section, then '$' terminator.
- Drives ready_fifo/ready_lifo back to CIPU as start/backpressure indication.

Parameters:
- DEPTH, 16, entries per internal char queue (power of 2, >=4)
- AW, $clog2(DEPTH), queue pointer width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- valid_fifo  in  1  passenger char valid (from CIPU)
- people_thing_out  in  8  passenger char
- done_fifo  in  1  passenger stream complete (level/pulse, latched)
- valid_lifo  in  1  thing char valid
- thing_out  in  8  thing char
- done_thing  in  1  one-cycle pulse: current thing group ended
- done_lifo  in  1  all thing groups issued (latched)
- ready_fifo  out  1  passenger queue can accept
- ready_lifo  out  1  thing queue can accept char plus separator
- out_valid  out  1  out_data valid
- out_data  out  8  merged output byte
- out_ready  in  1  sink accepts out_data
- out_last  out  1  high with the '$' byte only
- overflow_err  out  1  sticky: a push was dropped

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; queues empty; done latches, sep_pending, overflow_err, out_valid, out_last = 0; out_data=8'h00; ready_fifo=ready_lifo=0. Reset mid-operation discards all buffered data; no output after release until new input.
- Two queues (pq passenger, tq thing), DEPTH entries each, wrap-around pointers, count in AW+1 bits.
- ready_fifo = (state!=IDLE) && pq not full. ready_lifo = (state!=IDLE) && tq count <= DEPTH-2 && !sep_pending.
- Pushes accepted in any non-IDLE state except DONE:
  - valid_fifo pushes people_thing_out to pq.
  - valid_lifo pushes thing_out to tq.
  - done_thing pushes ';' to tq.
  - valid_lifo and done_thing in the same cycle: char pushed; sep_pending=1; ';' pushed next cycle.
- Push to a full queue: data dropped, overflow_err<=1 (sticky until reset). Inputs are not gated by ready; CIPU ignores backpressure.
- done_fifo/done_lifo latched sticky (done_p, done_t).
- Output register stage: load when (!out_valid || out_ready). out_data/out_valid held stable while out_valid && !out_ready. Same-cycle push and pop on one queue both occur; count unchanged.
- Latency: char pushed at edge N is on out_data after edge N+1, provided its queue is empty, the state selects it, and the output register is free.
- FSM:
  - IDLE: goes to THING on the first cycle after reset release.
  - THING: out register loads from tq. Go to PASS when done_t && tq empty && !sep_pending && output register loaded from tq is accepted or empty.
  - PASS: loads from pq. Go to TERM when done_p && pq empty.
  - TERM: load '$' with out_last=1; go to DONE when it is accepted.
  - DONE: out_valid=0, ready_*=0; hold until reset.
- Passenger chars arriving during THING are buffered, not emitted. Thing chars arriving in PASS/TERM are dropped and set overflow_err.

Optional Feature:
- CIPU_MERGE_CNT_EN defined: adds outputs pass_cnt[AW:0] and thing_cnt[AW:0].
  - Each counts accepted output handshakes of passenger chars and of thing chars (including ';').
  - Both are reset to 0, saturate at all-ones, and hold in DONE.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package cipu_pkg: state enum (IDLE, THING, PASS, TERM, DONE); constants SEP_CHAR=8'h3B, TERM_CHAR=8'h24.
- Sub-module cipu_char_q: synchronous FIFO, parameter DEPTH, push/pop/full/empty/count, same-cycle push+pop. Instantiated twice (pq, tq).

Test Plan:
- Basic: thing chars '3','2' then done_thing, '0' then done_thing, done_lifo; passengers 'A','B','C', done_fifo; out_ready=1 -> out_data "32;0;ABC$", out_last only on '$', then DONE with out_valid=0.
- Backpressure: same stimulus, out_ready toggling 1010… -> identical byte order, out_data stable whenever out_valid && !out_ready.
- Interleave: passengers 'X','Y' arrive before any thing char -> X,Y emitted only after the final ';' of the thing section; sequence "5;XY$".
- Simultaneous: valid_lifo='7' with done_thing in the same cycle -> "7;" emitted; ready_lifo low for one cycle during sep_pending.
- Overflow: 17 passenger chars with DEPTH=16 and no done_lifo -> ready_fifo=0 after 16; overflow_err=1; 16 chars emitted later.
- Reset mid-stream: rst=0 for one cycle after 2 thing chars -> out_valid=0, overflow_err=0; next run outputs only new data.
